hazard_unit_md: RTL

//  Hazard/forwarding controller for the 5-stage pipeline: E-stage and D-stage (branch) forwarding, load-use and

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/md_busy_tracker.sv | 32 +++
 rtl/hazard_unit_md.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit.
//  FWD_RF / FWD_WB / FWD_MEM : E-stage ALU operand mux selects
//  SRC_MAXW                  : widest register index src_match accepts
//  src_match(src, dst, we)   : true when a nonzero source register is produced
//                              by a stage that writes the register file
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int SRC_MAXW = 8;

    // Register 0 is hardwired to zero, so it never needs a forward or a stall.
    function automatic logic src_match(input logic [SRC_MAXW-1:0] src,
                                       input logic [SRC_MAXW-1:0] dst,
                                       input logic                we);
        return (src != '0) && (src == dst) && we;
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks the outstanding mult/div operation as a countdown.
//  clk   in  clock, rising edge
//  rst   in  synchronous active-high reset, discards any pending operation
//  start in  mult/div issued from E this cycle
//  busy  out result still pending (counter nonzero)
module md_busy_tracker #(
    parameter int LATENCY = 8,
    parameter int CW      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    logic [CW-1:0] r_mdCnt;

    // A new start always reloads the full latency, even if one is still
    // pending; otherwise count down to zero, where the result becomes readable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mdCnt <= '0;
        end else if (start) begin
            r_mdCnt <= CW'(LATENCY);
        end else if (r_mdCnt != '0) begin
            r_mdCnt <= r_mdCnt - 1'b1;
        end
    end

    assign busy = (r_mdCnt != '0);

endmodule

// File: rtl/hazard_unit_md.sv
// Hazard and forwarding controller for the 5-stage pipeline, with a mult/div
// HI/LO scoreboard and a stall-cycle performance counter.
//  clk, rst                      clock and synchronous active-high reset
//  RsD, RtD, RsE, RtE            source registers in D and E
//  WriteRegE/M/W, RegWriteE/M/W  destination register and write enable per stage
//  MemtoRegE/M                   stage holds a load
//  BranchD, JumpD, PCSrcD        control-flow instruction in D / branch taken
//  MdStartE, MdStartD, MdReadD   mult/div start in E or D, mfhi/mflo in D
//  StallF, StallD                hold PC and IF/ID
//  FlushD, FlushE                clear IF/ID and ID/EX
//  ForwardAD/BD                  branch comparator forwards from M
//  ForwardAE/BE                  ALU operand mux selects
//  MdBusy                        mult/div result pending
//  StallCount                    saturating count of cycles with StallD=1
module hazard_unit_md
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 8,
    parameter int MD_CW      = 4,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              MemtoRegM,
    input  logic              BranchD,
    input  logic              JumpD,
    input  logic              PCSrcD,
    input  logic              MdStartE,
    input  logic              MdStartD,
    input  logic              MdReadD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MdBusy,
    output logic [PERF_W-1:0] StallCount
);

    logic w_mdBusy;
    logic w_lwStall;
    logic w_branchStall;
    logic w_mdStall;
    logic w_stall;
    logic [PERF_W-1:0] r_stallCount;

    md_busy_tracker #(
        .LATENCY (MD_LATENCY),
        .CW      (MD_CW)
    ) u_mdBusy (
        .clk   (clk),
        .rst   (rst),
        .start (MdStartE),
        .busy  (w_mdBusy)
    );

    // Stall sources. A mult/div start still sitting in E counts as busy so
    // that an mfhi/mflo or second start right behind it is held too.
    always_comb begin
        w_lwStall = MemtoRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));
        w_branchStall = BranchD &&
            (src_match(SRC_MAXW'(WriteRegE), SRC_MAXW'(RsD), RegWriteE) ||
             src_match(SRC_MAXW'(WriteRegE), SRC_MAXW'(RtD), RegWriteE) ||
             src_match(SRC_MAXW'(WriteRegM), SRC_MAXW'(RsD), MemtoRegM) ||
             src_match(SRC_MAXW'(WriteRegM), SRC_MAXW'(RtD), MemtoRegM));
        w_mdStall = (MdReadD || MdStartD) && (w_mdBusy || MdStartE);
        w_stall   = w_lwStall || w_branchStall || w_mdStall;
    end

    // Output stage. Reset forces a bubble everywhere; a stall takes priority
    // over the D flush so the taken branch/jump is re-evaluated once released.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        MdBusy    = 1'b0;
        if (!rst) begin
            StallF    = w_stall;
            StallD    = w_stall;
            FlushE    = w_stall || JumpD;
            FlushD    = (PCSrcD || JumpD) && !w_stall;
            ForwardAD = src_match(SRC_MAXW'(RsD), SRC_MAXW'(WriteRegM), RegWriteM);
            ForwardBD = src_match(SRC_MAXW'(RtD), SRC_MAXW'(WriteRegM), RegWriteM);
            if (src_match(SRC_MAXW'(RsE), SRC_MAXW'(WriteRegM), RegWriteM)) begin
                ForwardAE = FWD_MEM;
            end else if (src_match(SRC_MAXW'(RsE), SRC_MAXW'(WriteRegW), RegWriteW)) begin
                ForwardAE = FWD_WB;
            end
            if (src_match(SRC_MAXW'(RtE), SRC_MAXW'(WriteRegM), RegWriteM)) begin
                ForwardBE = FWD_MEM;
            end else if (src_match(SRC_MAXW'(RtE), SRC_MAXW'(WriteRegW), RegWriteW)) begin
                ForwardBE = FWD_WB;
            end
            MdBusy = w_mdBusy;
        end
    end

    // Stall performance counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCount <= '0;
        end else if (w_stall && (r_stallCount != '1)) begin
            r_stallCount <= r_stallCount + 1'b1;
        end
    end

    assign StallCount = r_stallCount;

endmodule
